// File: rtl/axi_clkrst_pkg.sv
// axi_clkrst_pkg: shared sequencer states, reset defaults and width helper for axi_clkrst_seq
package axi_clkrst_pkg;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} seq_state_t;
  localparam int DIV_DEF = 1;
  localparam int RST_DLY_DEF = 16;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/axi_clkrst_div.sv
// axi_clkrst_div: one clock-enable divider channel with shadowed divide value; toggle flop built under AXI_CLKRST_TGL_EN
module axi_clkrst_div #(
  parameter int DIV_W = 16,
  parameter int DIV_DEF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic [DIV_W-1:0] val,
  output logic ce,
  output logic tgl
);
  logic [DIV_W-1:0] cnt, shadow, active;
  logic tc;
  assign tc = cnt == active;
  // count up to the active value; the shadow only reaches the active value at terminal count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      ce <= 1'b0;
      shadow <= DIV_W'(DIV_DEF);
      active <= DIV_W'(DIV_DEF);
    end else begin
      if (load) shadow <= val;
      cnt <= (en && !tc) ? cnt + 1'b1 : '0;
      ce <= en && tc;
      if (en && tc) active <= shadow;
    end
`ifdef AXI_CLKRST_TGL_EN
  // flip on every enable strobe, parked low while the channel is in reset
  always_ff @(posedge clk or posedge rst)
    if (rst) tgl <= 1'b0;
    else tgl <= en ? tgl ^ tc : 1'b0;
`else
  assign tgl = 1'b0;
`endif
endmodule

// File: rtl/axi_clkrst_seq.sv
// axi_clkrst_seq: NCH clock-enable dividers plus staggered active-low reset release; AXI_CLKRST_TGL_EN builds the CLK_TGL toggle flops
module axi_clkrst_seq #(
  parameter int NCH = 4,
  parameter int DIV_W = 16,
  parameter int DLY_W = 16,
  parameter int SEQ_GAP = 8,
  parameter int DIV_DEF = axi_clkrst_pkg::DIV_DEF,
  parameter int RST_DLY_DEF = axi_clkrst_pkg::RST_DLY_DEF
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic [NCH*DIV_W-1:0] DIV_VAL,
  input  logic [NCH-1:0] DIV_LOAD,
  input  logic SRST_REQ,
  input  logic [DLY_W-1:0] SRST_DLY,
  output logic [NCH-1:0] CE,
  output logic [NCH-1:0] CLK_TGL,
  output logic [NCH-1:0] RSTN_OUT,
  output logic BUSY
);
  import axi_clkrst_pkg::*;
  localparam int GW = clog2(SEQ_GAP + 1);
  seq_state_t state, state_nxt;
  logic [DLY_W-1:0] hcnt, hcnt_nxt, dly, dly_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic [NCH-1:0] rstn_nxt;
  // sequencer next state: resets release as a thermometer code growing from channel 0
  always_comb begin
    state_nxt = state;
    hcnt_nxt = hcnt;
    dly_nxt = dly;
    gcnt_nxt = '0;
    rstn_nxt = RSTN_OUT;
    if (SRST_REQ) begin
      state_nxt = HOLD;
      hcnt_nxt = '0;
      dly_nxt = SRST_DLY;
      rstn_nxt = '0;
    end else if (state == HOLD) begin
      rstn_nxt = (hcnt == dly) ? NCH'(1) : '0;
      hcnt_nxt = (hcnt == dly) ? hcnt : hcnt + 1'b1;
      state_nxt = (hcnt != dly) ? HOLD : (NCH == 1) ? RUN : RELEASE;
    end else if (state == RELEASE) begin
      gcnt_nxt = (gcnt == GW'(SEQ_GAP - 1)) ? '0 : gcnt + 1'b1;
      rstn_nxt = (gcnt == GW'(SEQ_GAP - 1)) ? (RSTN_OUT << 1) | NCH'(1) : RSTN_OUT;
      state_nxt = (&rstn_nxt) ? RUN : RELEASE;
    end
  end
  // sequencer registers; BUSY is registered from the next state so it falls with the last release
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state <= HOLD;
      hcnt <= '0;
      dly <= DLY_W'(RST_DLY_DEF);
      gcnt <= '0;
      RSTN_OUT <= '0;
      BUSY <= 1'b1;
    end else begin
      state <= state_nxt;
      hcnt <= hcnt_nxt;
      dly <= dly_nxt;
      gcnt <= gcnt_nxt;
      RSTN_OUT <= rstn_nxt;
      BUSY <= state_nxt != RUN;
    end
  // a channel counts only while its reset is released now and stays released, so a soft reset silences CE on the same edge
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    axi_clkrst_div #(.DIV_W(DIV_W), .DIV_DEF(DIV_DEF)) u_div (
      .clk(ACLK),
      .rst(ARESET),
      .en(RSTN_OUT[i] & rstn_nxt[i]),
      .load(DIV_LOAD[i]),
      .val(DIV_VAL[i*DIV_W +: DIV_W]),
      .ce(CE[i]),
      .tgl(CLK_TGL[i])
    );
  end
endmodule

// File: tb/tb_axi_clkrst_seq.sv
// tb_axi_clkrst_seq: scoreboard bench with an event-level reference model for axi_clkrst_seq
module tb_axi_clkrst_seq;
  localparam int NCH = 4, DIV_W = 16, DLY_W = 16, SEQ_GAP = 8, DIV_DEF = 1, RST_DLY_DEF = 16;
`ifdef AXI_CLKRST_TGL_EN
  localparam bit TGL_ON = 1'b1;
`else
  localparam bit TGL_ON = 1'b0;
`endif
  logic ACLK = 1'b0, ARESET = 1'b1, SRST_REQ = 1'b0, BUSY;
  logic [NCH*DIV_W-1:0] DIV_VAL = '0;
  logic [NCH-1:0] DIV_LOAD = '0, CE, CLK_TGL, RSTN_OUT;
  logic [DLY_W-1:0] SRST_DLY = '0;
  int tests = 0, fails = 0;
  typedef struct packed {logic [NCH-1:0] ce, tgl, rstn; logic busy;} out_t;
  out_t q[$];
  out_t mon_e;
  int t, d;
  int act[NCH], shd[NCH], left[NCH];
  logic [NCH-1:0] m_ce, m_tgl, m_rstn, nr, en;
  int rise[NCH];
  int bfall;
  bit found;

  always #5 ACLK = ~ACLK;

  axi_clkrst_seq #(.NCH(NCH), .DIV_W(DIV_W), .DLY_W(DLY_W), .SEQ_GAP(SEQ_GAP),
                   .DIV_DEF(DIV_DEF), .RST_DLY_DEF(RST_DLY_DEF)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .DIV_VAL(DIV_VAL), .DIV_LOAD(DIV_LOAD),
    .SRST_REQ(SRST_REQ), .SRST_DLY(SRST_DLY), .CE(CE), .CLK_TGL(CLK_TGL),
    .RSTN_OUT(RSTN_OUT), .BUSY(BUSY));

  // reference: channel k is released once t edges since the sequence start reach D+1+k*SEQ_GAP; dividers count down to the next strobe
  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      t = 0;
      d = RST_DLY_DEF;
      m_ce = '0;
      m_tgl = '0;
      m_rstn = '0;
      for (int c = 0; c < NCH; c++) begin
        act[c] = DIV_DEF;
        shd[c] = DIV_DEF;
        left[c] = DIV_DEF + 1;
      end
      q.delete();
    end else begin
      if (SRST_REQ) begin
        t = 0;
        d = int'(SRST_DLY);
      end else t++;
      for (int k = 0; k < NCH; k++) nr[k] = t >= d + 1 + k * SEQ_GAP;
      en = m_rstn & nr;
      for (int c = 0; c < NCH; c++) begin
        if (!en[c]) begin
          m_ce[c] = 1'b0;
          m_tgl[c] = 1'b0;
          left[c] = act[c] + 1;
        end else begin
          left[c]--;
          m_ce[c] = left[c] == 0;
          if (m_ce[c]) begin
            m_tgl[c] = ~m_tgl[c];
            act[c] = shd[c];
            left[c] = act[c] + 1;
          end
        end
        if (DIV_LOAD[c]) shd[c] = int'(DIV_VAL[c*DIV_W +: DIV_W]);
      end
      m_rstn = nr;
    end
    q.push_back('{ce: m_ce, tgl: (TGL_ON ? m_tgl : '0), rstn: m_rstn, busy: (m_rstn != '1)});
  end

  // monitor: compare every registered output once per cycle against the queued expectation
  always @(negedge ACLK) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      tests++;
      if ({CE, CLK_TGL, RSTN_OUT, BUSY} !== mon_e) begin
        fails++;
        $display("FAIL outputs @%0t: CE got %b want %b, CLK_TGL got %b want %b, RSTN_OUT got %b want %b, BUSY got %b want %b",
                 $time, CE, mon_e.ce, CLK_TGL, mon_e.tgl, RSTN_OUT, mon_e.rstn, BUSY, mon_e.busy);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic set_div(input int c, input int v);
    DIV_VAL[c*DIV_W +: DIV_W] = DIV_W'(v);
    DIV_LOAD[c] = 1'b1;
  endtask

  task automatic soft_rst(input int dl);
    SRST_DLY = DLY_W'(dl);
    SRST_REQ = 1'b1;
    tick(1);
    SRST_REQ = 1'b0;
  endtask

  task automatic measure(input int lim);
    for (int k = 0; k < NCH; k++) rise[k] = -1;
    bfall = -1;
    for (int n = 1; n <= lim; n++) begin
      tick(1);
      for (int k = 0; k < NCH; k++) if (rise[k] < 0 && RSTN_OUT[k]) rise[k] = n;
      if (bfall < 0 && !BUSY) bfall = n;
    end
  endtask

  initial begin
    tick(3);
    chk("reset_busy", BUSY, 1);
    chk("reset_rstn", RSTN_OUT, 0);
    ARESET = 1'b0;
    measure(60);
    chk("rise0_edge", rise[0], 17);
    chk("rise1_edge", rise[1], 25);
    chk("rise2_edge", rise[2], 33);
    chk("rise3_edge", rise[3], 41);
    chk("busy_fall_edge", bfall, 41);
    set_div(0, 3);
    set_div(1, 0);
    set_div(2, 9);
    tick(1);
    DIV_LOAD = '0;
    tick(30);
    for (int n = 0; n < 6; n++) begin
      chk("ce1_continuous", CE[1], 1);
      tick(1);
    end
    tick(3);
    set_div(2, 2);
    tick(1);
    DIV_LOAD = '0;
    tick(30);
    soft_rst(0);
    chk("srst_rstn_low", RSTN_OUT, 0);
    chk("srst_ce_low", CE, 0);
    tick(1);
    chk("srst_d0_rise0", RSTN_OUT[0], 1);
    chk("srst_d0_busy", BUSY, 1);
    tick(40);
    soft_rst(100);
    tick(49);
    soft_rst(5);
    measure(10);
    chk("srst_restart_rise0", rise[0], 6);
    tick(40);
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) DIV_VAL[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 5));
      DIV_LOAD = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      SRST_DLY = DLY_W'($urandom_range(0, 20));
      SRST_REQ = $urandom_range(0, 149) == 0;
      tick(1);
    end
    DIV_LOAD = '0;
    SRST_REQ = 1'b0;
    tick(60);
    soft_rst(3);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      tick(1);
      found = RSTN_OUT == 4'b0011;
    end
    chk("reach_two_released", found, 1);
    #1 ARESET = 1'b1;
    #1;
    chk("async_rstn", RSTN_OUT, 0);
    chk("async_ce", CE, 0);
    chk("async_tgl", CLK_TGL, 0);
    chk("async_busy", BUSY, 1);
    tick(2);
    ARESET = 1'b0;
    measure(20);
    chk("rearm_rise0", rise[0], 17);
    tick(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_clkrst_seq.md
# axi_clkrst_seq

Synthesizable, parametrised successor to the bench-only AXI clock/reset generator. It produces NCH clock-enable strobes, each from its own programmable divider, on the single ACLK domain. It also sequences per-channel active-low resets: after a programmable hold delay they release in channel order, with a fixed gap between channels. It sits between the top-level clock/reset pins and the AXI master/slave subsystems, and in benches it replaces the free-running toggle clock and the delay-task reset.

## Interface
- NCH, 4: number of channels (1..16).
- DIV_W, 16: width of each divide value.
- DLY_W, 16: width of the hold-delay value.
- SEQ_GAP, 8: ACLK cycles between successive channel releases (≥1).
- DIV_DEF, 1: reset value of every channel's active divide value.
- RST_DLY_DEF, 16: reset value of the captured hold delay.
- ACLK  in  1  sole clock; all state on its rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- DIV_VAL  in  NCH*DIV_W  per-channel divide values; channel c is bits [c*DIV_W +: DIV_W].
- DIV_LOAD  in  NCH  per-channel strobe; latches that channel's DIV_VAL into its shadow register.
- SRST_REQ  in  1  single-cycle soft-reset request.
- SRST_DLY  in  DLY_W  hold delay, captured when SRST_REQ is high.
- CE  out  NCH  clock-enable strobes, one cycle wide.
- CLK_TGL  out  NCH  divided 50%-style toggle outputs (data, not clocks).
- RSTN_OUT  out  NCH  per-channel active-low resets.
- BUSY  out  1  high while the sequencer is not in RUN.

## Operation
- Reset values:
  - CE = 0, CLK_TGL = 0, RSTN_OUT = 0, BUSY = 1.
  - Sequencer in HOLD; hold counter = 0; captured delay = RST_DLY_DEF.
  - Every shadow and active divide value = DIV_DEF.
- Divider channel c:
  - The counter is held at 0, and CE[c] and CLK_TGL[c] are held at 0, while RSTN_OUT[c] = 0.
  - Otherwise the counter increments each cycle. When counter == active value, CE[c] pulses, the counter returns to 0, and CLK_TGL[c] toggles.
  - Period is active value + 1 cycles. An active value of 0 gives CE[c] high continuously and CLK_TGL[c] toggling every cycle.
- Divide reload:
  - DIV_LOAD[c] writes the shadow register only.
  - The shadow is copied to the active value at the terminal count, so there is never a short or partial period.
  - If a load and a terminal count occur in the same cycle, the old shadow is applied and the new value takes effect at the following terminal count.
- Sequencer states:
  - HOLD: all RSTN_OUT = 0; the hold counter increments each cycle. When hold counter == captured delay, go to RELEASE and set RSTN_OUT[0] = 1 on the same edge.
  - RELEASE: a gap counter runs from 0 to SEQ_GAP-1. At SEQ_GAP-1, release the next channel. After channel NCH-1 is released, go to RUN on that edge.
  - RUN: all RSTN_OUT = 1; BUSY = 0.
- SRST_REQ, from any state: next state is HOLD. All RSTN_OUT drop on the next edge, SRST_DLY is captured, and the hold counter clears. A request during HOLD restarts the count with the new delay.
- ARESET mid-operation clears everything immediately to the reset values, asynchronously.
- Counter widths:
  - Hold counter is DLY_W bits; it cannot wrap because the compare precedes overflow.
  - Gap counter is ceil(log2(SEQ_GAP+1)) bits.
  - Divider counter is DIV_W bits.

## Timing
- With captured delay D, RSTN_OUT[0] rises on the (D+1)th edge after ARESET deasserts or after the SRST_REQ edge. D = 0 releases on the first edge.
- RSTN_OUT[k] rises k*SEQ_GAP edges after RSTN_OUT[0].
- BUSY falls on the same edge that RSTN_OUT[NCH-1] rises.
- First CE[c] occurs active value + 1 edges after RSTN_OUT[c] rises.
- All outputs are registered, with no combinational input-to-output path.
- SRST_REQ-to-RSTN_OUT-low latency is 1 edge.

## Configuration
- Macro AXI_CLKRST_TGL_EN.
- Defined: CLK_TGL toggle flops are built as described.
- Undefined: the toggle flops are omitted and CLK_TGL is tied to 0. The port list is unchanged, and CE behaviour is identical in both builds.

## Structure
- Shared package axi_clkrst_pkg holds:
  - the sequencer state enum (HOLD, RELEASE, RUN);
  - the default constants DIV_DEF and RST_DLY_DEF;
  - a clog2-style width function.
- Sub-module axi_clkrst_div contains one divider channel: counter, shadow/active registers and toggle flop. It is instantiated NCH times in a generate loop. The sequencer stays in the top level.

## Test plan
- NCH=4, RST_DLY_DEF=16, SEQ_GAP=8; release ARESET → RSTN_OUT[0] rises on edge 17, [1] on 25, [2] on 33, [3] on 41; BUSY falls on edge 41.
- In RUN, channel 0 loaded with DIV_VAL=3 → CE[0] pulses every 4 cycles and CLK_TGL[0] has a period of 8 cycles; channel 1 loaded with 0 → CE[1] stays high continuously.
- Channel 2 running at divide 9; mid-period DIV_LOAD with 2 → the current 10-cycle period completes, then the period is 3.
- In RUN, SRST_REQ with SRST_DLY=0 → all RSTN_OUT low on the next edge and CE all 0; RSTN_OUT[0] rises 1 edge later; BUSY high until the sequence ends.
- SRST_REQ with delay 100, then a second SRST_REQ with delay 5 after 50 cycles → RSTN_OUT[0] rises 6 edges after the second request.
- ARESET asserted during RELEASE with 2 channels released → all outputs return to reset values immediately and the sequence restarts from HOLD with delay RST_DLY_DEF. Repeat with AXI_CLKRST_TGL_EN undefined → CLK_TGL stays 0.
